// File: rtl/wash_controller_param_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : wash_controller_param_if                                     |
// | Description : Panel/sensor inputs and actuator outputs of the parametrised |
// |               washing-machine sequencer, bundled as one interface.         |
// |               master : panel/sensor side (drives requests and sensors)     |
// |               slave  : sequencer side (drives actuators and status)        |
// |   Inputs to sequencer : start, door_close, filled, drained,                |
// |                         detergent_added, pause                             |
// |   Outputs from it     : door_lock, motor_on, fill_valve_on,                |
// |                         drain_valve_on, soap_wash, rinse_count[RC_W],      |
// |                         done, error                                        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface wash_controller_param_if #(
  parameter int RC_W = 2
) ();
  logic            start;
  logic            door_close;
  logic            filled;
  logic            drained;
  logic            detergent_added;
  logic            pause;
  logic            door_lock;
  logic            motor_on;
  logic            fill_valve_on;
  logic            drain_valve_on;
  logic            soap_wash;
  logic [RC_W-1:0] rinse_count;
  logic            done;
  logic            error;

  modport master (
    output start, door_close, filled, drained, detergent_added, pause,
    input  door_lock, motor_on, fill_valve_on, drain_valve_on, soap_wash,
           rinse_count, done, error
  );

  modport slave (
    input  start, door_close, filled, drained, detergent_added, pause,
    output door_lock, motor_on, fill_valve_on, drain_valve_on, soap_wash,
           rinse_count, done, error
  );
endinterface
`default_nettype wire

// File: rtl/wash_controller_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : wash_controller_param                                        |
// | Description : Parametrised washing-machine sequencer. Soap pass followed   |
// |               by NUM_RINSES rinse passes and a final spin, with internal   |
// |               agitate/spin timers, pause, fill/drain watchdogs and a       |
// |               sticky fault state.                                          |
// |   clk   : rising-edge clock                                                |
// |   reset : asynchronous, active-low reset                                   |
// |   bus   : slave modport of wash_controller_param_if (sensors in,           |
// |           actuators/status out)                                            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module wash_controller_param #(
  parameter int WASH_CYCLES  = 16,
  parameter int SPIN_CYCLES  = 8,
  parameter int NUM_RINSES   = 2,
  parameter int FILL_TIMEOUT = 32,
  parameter int CNT_W        = 8,
  parameter int RC_W         = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  wash_controller_param_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FILL      = 3'd1,
    S_DETERGENT = 3'd2,
    S_AGITATE   = 3'd3,
    S_DRAIN     = 3'd4,
    S_SPIN      = 3'd5,
    S_DONE      = 3'd6,
    S_FAULT     = 3'd7
  } state_t;

  localparam logic [CNT_W-1:0] c_wash_last = CNT_W'(WASH_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_spin_last = CNT_W'(SPIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_wdog_last = CNT_W'(FILL_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);
  localparam logic [RC_W-1:0]  c_rinses    = RC_W'(NUM_RINSES);
  localparam logic [RC_W-1:0]  c_rc_one    = RC_W'(1);

  state_t            r_state;
  state_t            w_state_next;
  logic [CNT_W-1:0]  r_timer;
  logic [RC_W-1:0]   r_rinse_count;
  logic [RC_W-1:0]   w_rc_next;
  logic              w_locked;
  logic              w_timer_frozen;
  logic              w_door_lock;
  logic              w_motor_on;
  logic              w_fill_valve_on;
  logic              w_drain_valve_on;
  logic              w_soap_wash;
  logic              w_done;
  logic              w_error;

  // State, timer and pass index. The timer saturates rather than wrapping so
  // that long stays in the untimed states can never alias a limit value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_timer       <= '0;
      r_rinse_count <= '0;
    end else begin
      r_state       <= w_state_next;
      r_rinse_count <= w_rc_next;
      if (w_state_next != r_state) begin
        r_timer <= '0;
      end else if (!w_timer_frozen && (r_timer != '1)) begin
        r_timer <= r_timer + c_cnt_one;
      end
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_rc_next        = r_rinse_count;
    w_locked         = 1'b0;
    w_timer_frozen   = 1'b0;
    w_door_lock      = 1'b0;
    w_motor_on       = 1'b0;
    w_fill_valve_on  = 1'b0;
    w_drain_valve_on = 1'b0;
    w_soap_wash      = 1'b0;
    w_done           = 1'b0;
    w_error          = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.start && bus.door_close) begin
          w_state_next = S_FILL;
          w_rc_next    = '0;
        end
      end
      S_FILL: begin
        w_locked        = 1'b1;
        w_timer_frozen  = bus.pause;
        w_fill_valve_on = !bus.pause;
        w_soap_wash     = (r_rinse_count == '0);
        // A sensor hit wins over watchdog expiry in the same cycle; a paused
        // fill holds its watchdog as well as its timer.
        if (bus.filled) begin
          w_state_next = (r_rinse_count == '0) ? S_DETERGENT : S_AGITATE;
        end else if (!bus.pause && (r_timer == c_wdog_last)) begin
          w_state_next = S_FAULT;
        end
      end
      S_DETERGENT: begin
        w_locked    = 1'b1;
        w_soap_wash = (r_rinse_count == '0);
        if (bus.detergent_added) begin
          w_state_next = S_AGITATE;
        end
      end
      S_AGITATE: begin
        w_locked       = 1'b1;
        w_timer_frozen = bus.pause;
        w_motor_on     = !bus.pause;
        w_soap_wash    = (r_rinse_count == '0);
        if (!bus.pause && (r_timer == c_wash_last)) begin
          w_state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        w_locked         = 1'b1;
        w_drain_valve_on = 1'b1;
        w_soap_wash      = (r_rinse_count == '0);
        if (bus.drained) begin
          if (r_rinse_count == c_rinses) begin
            w_state_next = S_SPIN;
          end else begin
            w_state_next = S_FILL;
            w_rc_next    = r_rinse_count + c_rc_one;
          end
        end else if (r_timer == c_wdog_last) begin
          w_state_next = S_FAULT;
        end
      end
      S_SPIN: begin
        w_locked         = 1'b1;
        w_timer_frozen   = bus.pause;
        w_drain_valve_on = 1'b1;
        w_motor_on       = !bus.pause;
        if (!bus.pause && (r_timer == c_spin_last)) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        w_done = 1'b1;
        if (!bus.start) begin
          w_state_next = S_IDLE;
        end
      end
      S_FAULT: begin
        w_error          = 1'b1;
        w_drain_valve_on = 1'b1;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase

    // An open door while the drum is locked overrides every other transition.
    if (w_locked && !bus.door_close) begin
      w_state_next = S_FAULT;
      w_rc_next    = r_rinse_count;
    end

    w_door_lock = w_locked || w_error;
  end

  assign bus.door_lock      = w_door_lock;
  assign bus.motor_on       = w_motor_on;
  assign bus.fill_valve_on  = w_fill_valve_on;
  assign bus.drain_valve_on = w_drain_valve_on;
  assign bus.soap_wash      = w_soap_wash;
  assign bus.rinse_count    = r_rinse_count;
  assign bus.done           = w_done;
  assign bus.error          = w_error;

endmodule
`default_nettype wire

// File: tb/tb_wash_controller_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_wash_controller_param                                     |
// | Description : Self-checking bench for wash_controller_param. A phase-level |
// |               reference model (named phases, pass number, elapsed          |
// |               unpaused cycles) predicts all outputs each cycle; directed   |
// |               scenarios are followed by a randomized sensor soak.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_wash_controller_param;
  localparam int WASH_CYCLES  = 4;
  localparam int SPIN_CYCLES  = 3;
  localparam int NUM_RINSES   = 2;
  localparam int FILL_TIMEOUT = 8;
  localparam int CNT_W        = 8;
  localparam int RC_W         = 2;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  wash_controller_param_if #(.RC_W(RC_W)) bus ();

  wash_controller_param #(
    .WASH_CYCLES (WASH_CYCLES),
    .SPIN_CYCLES (SPIN_CYCLES),
    .NUM_RINSES  (NUM_RINSES),
    .FILL_TIMEOUT(FILL_TIMEOUT),
    .CNT_W       (CNT_W),
    .RC_W        (RC_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Reference model: phase name, wash pass and unpaused cycles spent in phase.
  string m_phase = "IDLE";
  int    m_pass  = 0;
  int    m_elapsed = 0;

  // Statistics gathered from DUT outputs.
  int agit_motor[3];
  int spin_motor, det_cycles, fill_cnt, soap_bad, cyc_count;
  int first_motor0, first_drain0;
  int seen_mask;

  function automatic bit in_phase(input string a, input string b, input string c,
                                  input string d, input string e);
    return (m_phase == a) || (m_phase == b) || (m_phase == c) ||
           (m_phase == d) || (m_phase == e);
  endfunction

  function automatic logic [8:0] observed();
    return {bus.door_lock, bus.motor_on, bus.fill_valve_on, bus.drain_valve_on,
            bus.soap_wash, bus.rinse_count, bus.done, bus.error};
  endfunction

  function automatic logic [8:0] model_outputs();
    logic dl, mo, fv, dv, sw, dn, er;
    logic [1:0] rc;
    dl = in_phase("FILL", "DETERGENT", "AGITATE", "DRAIN", "SPIN") || (m_phase == "FAULT");
    mo = ((m_phase == "AGITATE") || (m_phase == "SPIN")) && !bus.pause;
    fv = (m_phase == "FILL") && !bus.pause;
    dv = (m_phase == "DRAIN") || (m_phase == "SPIN") || (m_phase == "FAULT");
    sw = (m_pass == 0) && in_phase("FILL", "DETERGENT", "AGITATE", "DRAIN", "DRAIN");
    rc = 2'(m_pass);
    dn = (m_phase == "DONE");
    er = (m_phase == "FAULT");
    return {dl, mo, fv, dv, sw, rc, dn, er};
  endfunction

  task automatic model_step();
    string nxt;
    int    np;
    nxt = m_phase;
    np  = m_pass;
    if (in_phase("FILL", "DETERGENT", "AGITATE", "DRAIN", "SPIN") && !bus.door_close) begin
      nxt = "FAULT";
    end else if (m_phase == "IDLE") begin
      if (bus.start && bus.door_close) begin nxt = "FILL"; np = 0; end
    end else if (m_phase == "FILL") begin
      if (bus.filled) begin
        if (m_pass == 0) nxt = "DETERGENT";
        else             nxt = "AGITATE";
      end else if (!bus.pause && m_elapsed == FILL_TIMEOUT - 1) begin
        nxt = "FAULT";
      end
    end else if (m_phase == "DETERGENT") begin
      if (bus.detergent_added) nxt = "AGITATE";
    end else if (m_phase == "AGITATE") begin
      if (!bus.pause && m_elapsed == WASH_CYCLES - 1) nxt = "DRAIN";
    end else if (m_phase == "DRAIN") begin
      if (bus.drained) begin
        if (m_pass == NUM_RINSES) nxt = "SPIN";
        else begin nxt = "FILL"; np = m_pass + 1; end
      end else if (m_elapsed == FILL_TIMEOUT - 1) begin
        nxt = "FAULT";
      end
    end else if (m_phase == "SPIN") begin
      if (!bus.pause && m_elapsed == SPIN_CYCLES - 1) nxt = "DONE";
    end else if (m_phase == "DONE") begin
      if (!bus.start) nxt = "IDLE";
    end
    if (nxt != m_phase) m_elapsed = 0;
    else if (!(bus.pause && in_phase("FILL", "AGITATE", "SPIN", "SPIN", "SPIN"))) m_elapsed++;
    m_phase = nxt;
    m_pass  = np;
  endtask

  task automatic check_vec(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_val(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic reset_stats();
    for (int i = 0; i < 3; i++) agit_motor[i] = 0;
    spin_motor = 0; det_cycles = 0; fill_cnt = 0; soap_bad = 0; cyc_count = 0;
    first_motor0 = -1; first_drain0 = -1; seen_mask = 0;
  endtask

  // Inputs are already set; check this cycle's outputs at the falling edge,
  // then advance the model on the rising edge that the DUT samples.
  task automatic cycle();
    @(negedge clk);
    check_vec($sformatf("cycle_%s_pass%0d", m_phase, m_pass), observed(), model_outputs());
    cyc_count++;
    if (bus.door_lock && !bus.error) seen_mask |= (1 << bus.rinse_count);
    if (bus.motor_on && !bus.drain_valve_on) agit_motor[bus.rinse_count]++;
    if (bus.motor_on && bus.drain_valve_on) spin_motor++;
    if (bus.door_lock && !bus.motor_on && !bus.fill_valve_on && !bus.drain_valve_on &&
        !bus.error && !bus.pause) det_cycles++;
    if (bus.fill_valve_on) fill_cnt++;
    if (bus.soap_wash && bus.rinse_count != 0) soap_bad++;
    if (bus.motor_on && !bus.drain_valve_on && bus.rinse_count == 0 && first_motor0 < 0)
      first_motor0 = cyc_count;
    if (bus.drain_valve_on && bus.soap_wash && first_drain0 < 0) first_drain0 = cyc_count;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic clear_inputs();
    bus.start = 1'b0; bus.door_close = 1'b0; bus.filled = 1'b0;
    bus.drained = 1'b0; bus.detergent_added = 1'b0; bus.pause = 1'b0;
  endtask

  // Asynchronous reset pulse; outputs must drop before any clock edge.
  task automatic do_reset(input int pre_delay);
    #(pre_delay);
    reset = 1'b0;
    #1;
    check_vec("async_reset_outputs", observed(), 9'b0);
    m_phase = "IDLE"; m_pass = 0; m_elapsed = 0;
    clear_inputs();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic set_prompt();
    bus.filled          = (m_phase == "FILL");
    bus.drained         = (m_phase == "DRAIN");
    bus.detergent_added = (m_phase == "DETERGENT");
  endtask

  int pause_left;
  bit pause_done;

  initial begin
    clear_inputs();
    #1;
    check_vec("reset_state", observed(), 9'b0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Full run with prompt sensors and a 5-cycle pause in the soap agitation.
    reset_stats();
    bus.door_close = 1'b1; bus.start = 1'b1;
    pause_left = 0; pause_done = 1'b0;
    for (int i = 0; i < 300 && m_phase != "DONE"; i++) begin
      set_prompt();
      if (!pause_done && m_phase == "AGITATE" && m_pass == 0 && m_elapsed == 2) begin
        pause_left = 5; pause_done = 1'b1;
      end
      bus.pause = (pause_left > 0);
      cycle();
      if (pause_left > 0) pause_left--;
    end
    bus.pause = 1'b0;
    check_val("run_done", bus.done, 1);
    check_val("run_door_unlocked", bus.door_lock, 0);
    check_val("agit_motor_pass0", agit_motor[0], WASH_CYCLES);
    check_val("agit_motor_pass1", agit_motor[1], WASH_CYCLES);
    check_val("agit_motor_pass2", agit_motor[2], WASH_CYCLES);
    check_val("spin_motor", spin_motor, SPIN_CYCLES);
    check_val("detergent_visits", det_cycles, 1);
    check_val("passes_seen", seen_mask, 7);
    check_val("soap_outside_pass0", soap_bad, 0);
    check_val("agit_to_drain_with_pause", first_drain0 - first_motor0, WASH_CYCLES + 5);
    clear_inputs();
    bus.start = 1'b1; bus.door_close = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    check_val("done_held_start", bus.done, 1);
    bus.start = 1'b0;
    cycle();
    check_vec("idle_after_start_drop", observed(), {7'b0000010, 2'b00});
    bus.start = 1'b1;
    cycle();
    check_val("restart_fill", bus.fill_valve_on, 1);
    do_reset(0);

    // Fill watchdog.
    reset_stats();
    bus.door_close = 1'b1; bus.start = 1'b1;
    for (int i = 0; i < 30 && m_phase != "FAULT"; i++) cycle();
    check_val("fill_cycles_before_fault", fill_cnt, FILL_TIMEOUT);
    for (int i = 0; i < 3; i++) cycle();
    check_vec("fault_outputs", {5'b0, bus.error, bus.drain_valve_on, bus.fill_valve_on,
                                bus.door_lock}, 9'b000001101);
    do_reset(2);

    // filled arriving on the last watchdog cycle wins.
    bus.door_close = 1'b1; bus.start = 1'b1;
    cycle();
    for (int i = 0; i < FILL_TIMEOUT; i++) begin
      bus.filled = (i == FILL_TIMEOUT - 1);
      cycle();
    end
    check_vec("fill_at_limit", {6'b0, bus.door_lock, bus.fill_valve_on, bus.error}, 9'b000000100);
    bus.filled = 1'b0;
    cycle();
    do_reset(0);

    // Door opened during spin.
    bus.door_close = 1'b1; bus.start = 1'b1;
    for (int i = 0; i < 200 && m_phase != "SPIN"; i++) begin set_prompt(); cycle(); end
    clear_inputs(); bus.door_close = 1'b1; bus.start = 1'b1;
    cycle();
    bus.door_close = 1'b0;
    cycle();
    check_vec("door_drop_spin", {7'b0, bus.motor_on, bus.error}, 9'b000000001);
    cycle();
    do_reset(1);

    // Reset during the pass-1 drain.
    bus.door_close = 1'b1; bus.start = 1'b1;
    for (int i = 0; i < 200 && !(m_phase == "DRAIN" && m_pass == 1); i++) begin
      set_prompt(); cycle();
    end
    bus.drained = 1'b0; bus.filled = 1'b0;
    cycle();
    cycle();
    check_val("pre_reset_drain_pass1", {bus.drain_valve_on, bus.rinse_count}, 5);
    do_reset(2);
    check_vec("idle_after_midreset", observed(), 9'b0);

    // Randomized soak against the model.
    for (int i = 0; i < 4000; i++) begin
      if (m_phase == "FAULT" || $urandom_range(0, 499) == 0) begin
        do_reset(int'($urandom_range(0, 3)));
      end else begin
        bus.start           = ($urandom_range(0, 3) != 0);
        bus.door_close      = ($urandom_range(0, 99) != 0);
        bus.filled          = ($urandom_range(0, 9) < 3);
        bus.drained         = ($urandom_range(0, 9) < 3);
        bus.detergent_added = ($urandom_range(0, 9) < 4);
        bus.pause           = (m_phase != "FILL") && ($urandom_range(0, 4) == 0);
        cycle();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire
